// File: rtl/qeciphy_pkg.sv
// -----------------------------------------------------------------------------
// qeciphy_pkg
// Shared types and constants for the QECIPHY multi-lane link controller.
//   link_state_e : link status values, encoded exactly as reported on o_state
//   ecode_e      : error codes reported on o_ecode
//   lane_stage_e : which per-lane readiness vector the lane reducer examines
//   *_MIN/*_MAX  : legal ranges of the controller parameters
//   TMO_CNT_W    : width of the optional training timeout counter
// -----------------------------------------------------------------------------
package qeciphy_pkg;

    typedef enum logic [3:0] {
        StReset     = 4'd0,
        StWaitReset = 4'd1,
        StTraining  = 4'd2,
        StRxLocked  = 4'd3,
        StLinkReady = 4'd4,
        StFault     = 4'd5,
        StSleep     = 4'd6
    } link_state_e;

    typedef enum logic [3:0] {
        EcNone       = 4'd0,
        EcFapMissing = 4'd1,
        EcCrcError   = 4'd2,
        EcTimeout    = 4'd3
    } ecode_e;

    typedef enum logic [1:0] {
        StageResetDone = 2'd0,
        StageRxRdy     = 2'd1,
        StageRemoteRdy = 2'd2
    } lane_stage_e;

    localparam int unsigned N_LANES_MIN        = 1;
    localparam int unsigned N_LANES_MAX        = 8;
    localparam int unsigned RST_CYCLES_MIN     = 2;
    localparam int unsigned RST_CYCLES_MAX     = 255;
    localparam int unsigned TIMEOUT_CYCLES_MIN = 16;
    localparam int unsigned TIMEOUT_CYCLES_MAX = 32'd1 << 24;

    // Holds values up to TIMEOUT_CYCLES_MAX inclusive.
    localparam int unsigned TMO_CNT_W = 25;

    // Readiness vector that gates the exit from each waiting state.
    function automatic lane_stage_e stage_of(input link_state_e s);
        case (s)
            StTraining: return StageRxRdy;
            StRxLocked: return StageRemoteRdy;
            default:    return StageResetDone;
        endcase
    endfunction

endpackage

// File: rtl/qeciphy_lane_reducer.sv
// -----------------------------------------------------------------------------
// qeciphy_lane_reducer
// Registers every per-lane status vector once, then reduces the registered
// copies: the AND of the readiness vector selected by i_stage, the lanes of
// that vector that are still not ready, and the OR / mask of the lane error
// flags that the controller captures on its first error.
//
// Ports
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_stage            : readiness vector to reduce (reset done, rx, remote rx)
//   i_reset_done       : per-lane reset controller done
//   i_rx_rdy           : per-lane local word alignment
//   i_remote_rx_rdy    : per-lane remote word alignment
//   i_fap_missing      : per-lane FAP missing flag
//   i_crc_error        : per-lane CRC error flag
//   o_stage_ready      : all lanes of the selected vector ready (registered inputs)
//   o_stage_lagging    : lanes of the selected vector not yet ready
//   o_fap_any          : any lane reported FAP missing last cycle
//   o_crc_any          : any lane reported CRC error last cycle
//   o_err_mask         : lanes that reported any error last cycle
// -----------------------------------------------------------------------------
module qeciphy_lane_reducer
    import qeciphy_pkg::*;
#(
    parameter int unsigned N_LANES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  lane_stage_e        i_stage,
    input  logic [N_LANES-1:0] i_reset_done,
    input  logic [N_LANES-1:0] i_rx_rdy,
    input  logic [N_LANES-1:0] i_remote_rx_rdy,
    input  logic [N_LANES-1:0] i_fap_missing,
    input  logic [N_LANES-1:0] i_crc_error,
    output logic               o_stage_ready,
    output logic [N_LANES-1:0] o_stage_lagging,
    output logic               o_fap_any,
    output logic               o_crc_any,
    output logic [N_LANES-1:0] o_err_mask
);

    logic [N_LANES-1:0] r_reset_done;
    logic [N_LANES-1:0] r_rx_rdy;
    logic [N_LANES-1:0] r_remote_rdy;
    logic [N_LANES-1:0] r_fap;
    logic [N_LANES-1:0] r_crc;
    logic [N_LANES-1:0] w_sel;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_reset_done <= '0;
            r_rx_rdy     <= '0;
            r_remote_rdy <= '0;
            r_fap        <= '0;
            r_crc        <= '0;
        end else begin
            r_reset_done <= i_reset_done;
            r_rx_rdy     <= i_rx_rdy;
            r_remote_rdy <= i_remote_rx_rdy;
            r_fap        <= i_fap_missing;
            r_crc        <= i_crc_error;
        end
    end

    always_comb begin
        w_sel = r_reset_done;
        case (i_stage)
            StageRxRdy:     w_sel = r_rx_rdy;
            StageRemoteRdy: w_sel = r_remote_rdy;
            default:        w_sel = r_reset_done;
        endcase
    end

    assign o_stage_ready   = &w_sel;
    assign o_stage_lagging = ~w_sel;
    assign o_fap_any       = |r_fap;
    assign o_crc_any       = |r_crc;
    assign o_err_mask      = r_fap | r_crc;

endmodule

// File: rtl/qeciphy_multilane_controller.sv
// -----------------------------------------------------------------------------
// qeciphy_multilane_controller
// Link controller for N_LANES bonded QECIPHY lanes: holds the lanes in reset,
// walks the link through reset-done, local alignment and remote alignment,
// latches the first lane error as a terminal fault, and handles the
// sleep/wake power handshake.
//
// Optional feature: define QECIPHY_TRAIN_TIMEOUT_EN to fault the link with
// error code 3 when WAIT_RESET/TRAINING/RX_LOCKED lasts TIMEOUT_CYCLES cycles.
//
// Ports
//   axis_clk, axis_rst_n : clock, synchronous active-low reset
//   i_reset_done         : per-lane reset controller done
//   i_rx_rdy             : per-lane local word alignment achieved
//   i_remote_rx_rdy      : per-lane remote word alignment achieved
//   i_fap_missing        : per-lane FAP missing flag
//   i_crc_error          : per-lane CRC error flag
//   i_tx_tvalid          : user TX traffic present
//   i_pstate, i_preq     : power request (pstate 0 = sleep, 1 = run)
//   o_paccept            : one-cycle power request accept
//   o_pactive            : wake request (registered i_tx_tvalid while asleep)
//   o_state              : link status (link_state_e encoding)
//   o_ecode              : error code (ecode_e encoding), held in FAULT
//   o_lane_rst_n         : per-lane reset, active low
//   o_fault_lanes        : sticky mask of lanes that caused FAULT
//   o_allow_user_tx      : high only in LINK_READY
// -----------------------------------------------------------------------------
module qeciphy_multilane_controller
    import qeciphy_pkg::*;
#(
    parameter int unsigned N_LANES        = 4,
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic               axis_clk,
    input  logic               axis_rst_n,
    input  logic [N_LANES-1:0] i_reset_done,
    input  logic [N_LANES-1:0] i_rx_rdy,
    input  logic [N_LANES-1:0] i_remote_rx_rdy,
    input  logic [N_LANES-1:0] i_fap_missing,
    input  logic [N_LANES-1:0] i_crc_error,
    input  logic               i_tx_tvalid,
    input  logic               i_pstate,
    input  logic               i_preq,
    output logic               o_paccept,
    output logic               o_pactive,
    output logic [3:0]         o_state,
    output logic [3:0]         o_ecode,
    output logic [N_LANES-1:0] o_lane_rst_n,
    output logic [N_LANES-1:0] o_fault_lanes,
    output logic               o_allow_user_tx
);

    if (N_LANES < N_LANES_MIN || N_LANES > N_LANES_MAX) begin : g_bad_n_lanes
        $error("N_LANES out of range");
    end
    if (RST_CYCLES < RST_CYCLES_MIN || RST_CYCLES > RST_CYCLES_MAX) begin : g_bad_rst_cycles
        $error("RST_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < TIMEOUT_CYCLES_MIN || TIMEOUT_CYCLES > TIMEOUT_CYCLES_MAX)
    begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end

    link_state_e        r_state;
    ecode_e             r_ecode;
    logic [7:0]         r_rst_cnt;
    logic [N_LANES-1:0] r_lane_rst_n;
    logic [N_LANES-1:0] r_fault_lanes;
    logic               r_paccept;
    logic               r_pactive;
    logic               r_allow_tx;

    lane_stage_e        w_stage;
    logic               w_stage_ready;
    logic [N_LANES-1:0] w_stage_lagging;
    logic               w_fap_any;
    logic               w_crc_any;
    logic [N_LANES-1:0] w_err_mask;
    logic               w_in_link;
    logic               w_fault_go;
    logic               w_tmo_hit;
    logic               w_raw_err;
    logic               w_sleep_req;
    logic               w_wake_req;

    assign w_stage = stage_of(r_state);

    qeciphy_lane_reducer #(
        .N_LANES (N_LANES)
    ) u_lane_reducer (
        .i_clk           (axis_clk),
        .i_rst_n         (axis_rst_n),
        .i_stage         (w_stage),
        .i_reset_done    (i_reset_done),
        .i_rx_rdy        (i_rx_rdy),
        .i_remote_rx_rdy (i_remote_rx_rdy),
        .i_fap_missing   (i_fap_missing),
        .i_crc_error     (i_crc_error),
        .o_stage_ready   (w_stage_ready),
        .o_stage_lagging (w_stage_lagging),
        .o_fap_any       (w_fap_any),
        .o_crc_any       (w_crc_any),
        .o_err_mask      (w_err_mask)
    );

    // Lane errors only count once the lanes are out of reset and training.
    assign w_in_link  = (r_state == StTraining) || (r_state == StRxLocked) ||
                        (r_state == StLinkReady);
    assign w_fault_go = w_in_link && (w_fap_any || w_crc_any);

    // An error on the raw inputs blocks a sleep accept so the fault, which
    // shows up a cycle later through the reducer, is never preceded by SLEEP.
    assign w_raw_err   = (|i_fap_missing) || (|i_crc_error);
    assign w_sleep_req = i_preq && !i_pstate;
    assign w_wake_req  = i_preq && i_pstate;

`ifdef QECIPHY_TRAIN_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] r_tmo_cnt;
    logic                 w_counting;

    assign w_counting = (r_state == StWaitReset) || (r_state == StTraining) ||
                        (r_state == StRxLocked);
    assign w_tmo_hit  = w_counting && !w_stage_ready &&
                        (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts only while the FSM stays put, so any state change clears it.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_counting && !w_stage_ready && !w_fault_go && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_state       <= StReset;
            r_ecode       <= EcNone;
            r_rst_cnt     <= '0;
            r_lane_rst_n  <= '0;
            r_fault_lanes <= '0;
            r_paccept     <= 1'b0;
            r_pactive     <= 1'b0;
            r_allow_tx    <= 1'b0;
        end else begin
            r_paccept <= 1'b0;
            if (w_fault_go || w_tmo_hit) begin
                // Lane errors outrank the timeout; FAP outranks CRC.
                r_state    <= StFault;
                r_allow_tx <= 1'b0;
                r_pactive  <= 1'b0;
                if (w_fault_go) begin
                    r_ecode       <= w_fap_any ? EcFapMissing : EcCrcError;
                    r_fault_lanes <= w_err_mask;
                end else begin
                    r_ecode       <= EcTimeout;
                    r_fault_lanes <= w_stage_lagging;
                end
            end else begin
                case (r_state)
                    StReset: begin
                        r_allow_tx <= 1'b0;
                        r_pactive  <= 1'b0;
                        if (r_rst_cnt == 8'(RST_CYCLES - 1)) begin
                            r_state      <= StWaitReset;
                            r_lane_rst_n <= '1;
                            r_rst_cnt    <= '0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 8'd1;
                        end
                    end
                    StWaitReset: begin
                        if (w_stage_ready) begin
                            r_state <= StTraining;
                        end
                    end
                    StTraining: begin
                        if (w_stage_ready) begin
                            r_state <= StRxLocked;
                        end
                    end
                    StRxLocked: begin
                        if (w_stage_ready) begin
                            r_state    <= StLinkReady;
                            r_allow_tx <= 1'b1;
                        end
                    end
                    StLinkReady: begin
                        // Request is level sensitive: dropping i_preq cancels it.
                        if (w_sleep_req && !i_tx_tvalid && !w_raw_err) begin
                            r_state      <= StSleep;
                            r_paccept    <= 1'b1;
                            r_allow_tx   <= 1'b0;
                            r_lane_rst_n <= '0;
                            r_pactive    <= 1'b0;
                        end
                    end
                    StFault: begin
                        r_allow_tx <= 1'b0;
                    end
                    StSleep: begin
                        r_pactive <= i_tx_tvalid;
                        if (w_wake_req) begin
                            r_state   <= StReset;
                            r_paccept <= 1'b1;
                            r_pactive <= 1'b0;
                            r_rst_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= StReset;
                    end
                endcase
            end
        end
    end

    assign o_state         = r_state;
    assign o_ecode         = r_ecode;
    assign o_lane_rst_n    = r_lane_rst_n;
    assign o_fault_lanes   = r_fault_lanes;
    assign o_paccept       = r_paccept;
    assign o_pactive       = r_pactive;
    assign o_allow_user_tx = r_allow_tx;

endmodule

// File: tb/tb_qeciphy_multilane_controller.sv
// -----------------------------------------------------------------------------
// tb_qeciphy_multilane_controller
// Directed, table-driven bench for qeciphy_multilane_controller with
// N_LANES=4, RST_CYCLES=16, TIMEOUT_CYCLES=64. Inputs change on the falling
// edge; outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_qeciphy_multilane_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] reset_done, rx_rdy, remote_rdy, fap, crc;
    logic       tvalid, pstate, preq;
    logic       paccept, pactive, allow_tx;
    logic [3:0] state, ecode, lane_rst_n, fault_lanes;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    qeciphy_multilane_controller #(
        .N_LANES        (4),
        .RST_CYCLES     (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .axis_clk        (clk),
        .axis_rst_n      (rst_n),
        .i_reset_done    (reset_done),
        .i_rx_rdy        (rx_rdy),
        .i_remote_rx_rdy (remote_rdy),
        .i_fap_missing   (fap),
        .i_crc_error     (crc),
        .i_tx_tvalid     (tvalid),
        .i_pstate        (pstate),
        .i_preq          (preq),
        .o_paccept       (paccept),
        .o_pactive       (pactive),
        .o_state         (state),
        .o_ecode         (ecode),
        .o_lane_rst_n    (lane_rst_n),
        .o_fault_lanes   (fault_lanes),
        .o_allow_user_tx (allow_tx)
    );

    typedef struct {
        int         grp;
        logic [3:0] fap, crc;
        logic       tv, pr, ps;
        logic [3:0] st, ec, ln, flt;
        logic       pa, pv, al;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int g, input logic [3:0] f, input logic [3:0] c,
                                input logic tv, input logic pr, input logic ps,
                                input logic [3:0] st, input logic [3:0] ec,
                                input logic [3:0] ln, input logic [3:0] flt,
                                input logic pa, input logic pv, input logic al);
        vec_t v;
        v.grp = g; v.fap = f; v.crc = c; v.tv = tv; v.pr = pr; v.ps = ps;
        v.st = st; v.ec = ec; v.ln = ln; v.flt = flt; v.pa = pa; v.pv = pv; v.al = al;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_ecode"}, ecode, 0);
        check({tag, "_lane_rst_n"}, lane_rst_n, 0);
        check({tag, "_fault_lanes"}, fault_lanes, 0);
        check({tag, "_paccept"}, paccept, 0);
        check({tag, "_pactive"}, pactive, 0);
        check({tag, "_allow_tx"}, allow_tx, 0);
    endtask

    // Called on a falling edge; leaves reset released on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0; fap = '0; crc = '0; tvalid = 1'b0;
        @(posedge clk); @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts lane-reset-low samples from the current one, then follows training.
    task automatic wait_train();
        int cnt = 0;
        while (lane_rst_n !== 4'hF && cnt < 64) begin
            cnt++;
            @(negedge clk);
        end
        check("rst_low_cycles", cnt, 16);
        check("st_wait_reset", state, 1);
        @(negedge clk); check("st_training", state, 2);
        @(negedge clk); check("st_rx_locked", state, 3);
        @(negedge clk); check("st_link_ready", state, 4);
        check("allow_tx_ready", allow_tx, 1);
        check("no_paccept_bringup", paccept, 0);
    endtask

    task automatic bring_up();
        reset_done = 4'hF; rx_rdy = 4'hF; remote_rdy = 4'hF;
        do_reset();
        wait_train();
    endtask

    task automatic run_group(input int g);
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                fap = vecs[i].fap; crc = vecs[i].crc;
                tvalid = vecs[i].tv; preq = vecs[i].pr; pstate = vecs[i].ps;
                @(posedge clk); @(negedge clk);
                check($sformatf("g%0d_v%0d_state", g, i), state, vecs[i].st);
                check($sformatf("g%0d_v%0d_ecode", g, i), ecode, vecs[i].ec);
                check($sformatf("g%0d_v%0d_lane_rst_n", g, i), lane_rst_n, vecs[i].ln);
                check($sformatf("g%0d_v%0d_fault_lanes", g, i), fault_lanes, vecs[i].flt);
                check($sformatf("g%0d_v%0d_paccept", g, i), paccept, vecs[i].pa);
                check($sformatf("g%0d_v%0d_pactive", g, i), pactive, vecs[i].pv);
                check($sformatf("g%0d_v%0d_allow_tx", g, i), allow_tx, vecs[i].al);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Group 1: CRC pulse on lane 2 in LINK_READY, fault is terminal.
        vecs.push_back(mk(1, 4'h0, 4'h4, 0, 0, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 4'd5, 4'd2, 4'hF, 4'h4, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 1, 1, 4'd5, 4'd2, 4'hF, 4'h4, 0, 0, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 0, 0, 0, 4'd5, 4'd2, 4'hF, 4'h4, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 4'd5, 4'd2, 4'hF, 4'h4, 0, 0, 0));
        // Group 2: FAP and CRC on lanes 0 and 3 together, FAP wins.
        vecs.push_back(mk(2, 4'h9, 4'h9, 0, 0, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(2, 4'h0, 4'h0, 0, 0, 0, 4'd5, 4'd1, 4'hF, 4'h9, 0, 0, 0));
        // Group 3: sleep held off by traffic, accepted, pactive, wake.
        vecs.push_back(mk(3, 4'h0, 4'h0, 1, 1, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(3, 4'h0, 4'h0, 1, 1, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(3, 4'h0, 4'h0, 0, 1, 0, 4'd6, 4'd0, 4'h0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(3, 4'h0, 4'h0, 0, 0, 0, 4'd6, 4'd0, 4'h0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(3, 4'h0, 4'h0, 1, 0, 0, 4'd6, 4'd0, 4'h0, 4'h0, 0, 1, 0));
        vecs.push_back(mk(3, 4'h0, 4'h0, 1, 1, 0, 4'd6, 4'd0, 4'h0, 4'h0, 0, 1, 0));
        vecs.push_back(mk(3, 4'h0, 4'h0, 0, 1, 1, 4'd0, 4'd0, 4'h0, 4'h0, 1, 0, 0));
        // Group 4: request withdrawn before accept.
        vecs.push_back(mk(4, 4'h0, 4'h0, 1, 1, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(4, 4'h0, 4'h0, 0, 0, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(4, 4'h0, 4'h0, 0, 0, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        // Group 5: lane error in the same cycle as a sleep request.
        vecs.push_back(mk(5, 4'h2, 4'h0, 0, 1, 0, 4'd4, 4'd0, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(5, 4'h0, 4'h0, 0, 1, 0, 4'd5, 4'd1, 4'hF, 4'h2, 0, 0, 0));
        // Group 6: sleep request pending since reset, accepted in LINK_READY.
        vecs.push_back(mk(6, 4'h0, 4'h0, 0, 1, 0, 4'd6, 4'd0, 4'h0, 4'h0, 1, 0, 0));

        rst_n = 1'b0; reset_done = '0; rx_rdy = '0; remote_rdy = '0;
        fap = '0; crc = '0; tvalid = 1'b0; pstate = 1'b0; preq = 1'b0;
        @(negedge clk);

        bring_up(); run_group(1);
        bring_up(); run_group(2);
        bring_up(); run_group(3);
        preq = 1'b0; pstate = 1'b0;
        wait_train();
        bring_up(); run_group(4);
        bring_up(); run_group(5);

        // Reset pulsed while in RX_LOCKED.
        preq = 1'b0;
        reset_done = 4'hF; rx_rdy = 4'hF; remote_rdy = 4'hF;
        do_reset();
        begin
            int guard = 0;
            while (state !== 4'd3 && guard < 64) begin
                guard++;
                @(negedge clk);
            end
        end
        check("reached_rx_locked", state, 3);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check_reset_vals("midrst");
        rst_n = 1'b1;
        wait_train();

        preq = 1'b1; pstate = 1'b0;
        bring_up(); run_group(6);

        // Lane 1 never reaches local alignment.
        preq = 1'b0; pstate = 1'b0;
        reset_done = 4'hF; rx_rdy = 4'hD; remote_rdy = 4'hF;
        do_reset();
        begin
            int cnt = 0;
            while (lane_rst_n !== 4'hF && cnt < 64) begin
                cnt++;
                @(negedge clk);
            end
            check("tmo_rst_low_cycles", cnt, 16);
        end
        check("tmo_st_wait_reset", state, 1);
        @(negedge clk);
        check("tmo_st_training", state, 2);
`ifdef QECIPHY_TRAIN_TIMEOUT_EN
        begin
            int n2 = 0;
            while (state === 4'd2 && n2 < 200) begin
                n2++;
                @(negedge clk);
            end
            check("tmo_training_cycles", n2, 64);
        end
        check("tmo_state", state, 5);
        check("tmo_ecode", ecode, 3);
        check("tmo_fault_lanes", fault_lanes, 4'h2);
        check("tmo_allow_tx", allow_tx, 0);
`else
        repeat (100) @(negedge clk);
        check("notmo_state", state, 2);
        check("notmo_ecode", ecode, 0);
        check("notmo_fault_lanes", fault_lanes, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
